regfile_dump_ctrl: RTL and testbench

REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_dump_ctrl.sv | 98 +++++++++
 tb/tb_regfile_dump_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and FSM state encoding for the register-file dump/load controller.
package regfile_pkg;
    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMP,
        S_DRAIN,
        S_LOAD,
        S_DONE
    } state_e;
endpackage

// File: rtl/regfile_dump_ctrl.sv
// Streams a block of register-file words out (dump) or writes a stream into the
// register file (load), with abort and a one-cycle done pulse on completion.
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_rd,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DATA_W-1:0] din_data
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(1) << ADDR_W;

    state_e              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remaining;
    logic                r_dout_valid;
    logic [DATA_W-1:0]   r_dout_data;

    logic w_last, w_abort, w_dump_cap, w_drain_acc, w_load_acc;

    assign w_last      = (r_remaining == (ADDR_W+1)'(1));
    assign w_abort     = abort && (r_state != S_IDLE);
    // Output register refills whenever it is empty or being emptied this edge.
    assign w_dump_cap  = (r_state == S_DUMP) && (!r_dout_valid || dout_ready);
    assign w_drain_acc = (r_state == S_DRAIN) && dout_ready;
    assign w_load_acc  = (r_state == S_LOAD) && din_valid && !abort;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = mode ? S_LOAD : S_DUMP;
            S_DUMP:  if (w_dump_cap && w_last) w_next = S_DRAIN;
            S_DRAIN: if (w_drain_acc) w_next = S_DONE;
            S_LOAD:  if (w_load_acc && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_dout_valid <= 1'b0;
            r_dout_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_addr      <= base;
                r_remaining <= (count == '0) ? FULL_COUNT : count;
            end else if (w_abort) begin
                r_dout_valid <= 1'b0;
            end else if (w_dump_cap) begin
                r_dout_data  <= rf_rd;
                r_dout_valid <= 1'b1;
                r_addr       <= r_addr + ADDR_W'(1);
                r_remaining  <= r_remaining - (ADDR_W+1)'(1);
            end else if (w_drain_acc) begin
                r_dout_valid <= 1'b0;
            end else if (w_load_acc) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - (ADDR_W+1)'(1);
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign rf_ra      = r_addr;
    assign dout_valid = r_dout_valid;
    assign dout_data  = r_dout_data;
    assign din_ready  = (r_state == S_LOAD);
    // Register 0 is hard-wired; the word is still consumed and counted.
    assign rf_we      = w_load_acc && (r_addr != '0);
    assign rf_wa      = r_addr;
    assign rf_wd      = din_data;
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl with an inline register-file model.
module tb_regfile_dump_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   count = '0;
    logic          abort = 1'b0;
    logic          dout_ready = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din_data = '0;
    logic          busy, done, rf_we, dout_valid, din_ready;
    logic [AW-1:0] rf_ra, rf_wa;
    logic [DW-1:0] rf_rd, rf_wd, dout_data;

    logic [DW-1:0] rf [32];
    logic          preload_req = 1'b0;

    regfile_dump_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base(base),
        .count(count), .abort(abort), .busy(busy), .done(done),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data)
    );

    always #5 clk = ~clk;

    assign rf_rd = rf[rf_ra];
    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < 32; i++) rf[i] <= i;
        end else if (rf_we) begin
            rf[rf_wa] <= rf_wd;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   count;
        int            n;
        logic [DW-1:0] first;
        int            stall_at;
    } dvec_t;

    dvec_t vecs [6];

    function automatic logic [DW-1:0] expw(input logic [DW-1:0] first, input int i);
        return (first + DW'(i)) & 32'h1f;
    endfunction

    task automatic run_dump(input dvec_t v);
        int words, dones, done_words, first_cyc, last_cyc, stall;
        bit stalled;
        words = 0; dones = 0; done_words = -1; first_cyc = -1; last_cyc = -1;
        stall = 0; stalled = 0;
        @(negedge clk);
        base = v.base; count = v.count; mode = 1'b0; start = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("dump_busy_rise", busy, 1);
        chk("dump_first_valid_low", dout_valid, 0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            start = (cyc == 1);
            mode  = (cyc == 1);
            if (v.stall_at >= 0 && !stalled && words == v.stall_at && dout_valid) begin
                stall = 4; stalled = 1;
            end
            dout_ready = (stall == 0);
            if (stall > 0) begin
                chk("stall_hold_valid", dout_valid, 1);
                chk("stall_hold_data", dout_data, expw(v.first, words));
                stall--;
            end
            if (dout_valid && dout_ready) begin
                chk("dump_word", dout_data, expw(v.first, words));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                words++;
            end
            if (done) begin
                dones++;
                done_words = words;
            end
            if (!busy) begin
                start = 1'b0; mode = 1'b0;
                break;
            end
        end
        start = 1'b0; mode = 1'b0; dout_ready = 1'b1;
        chk("dump_word_count", words, v.n);
        chk("dump_done_pulses", dones, 1);
        chk("dump_done_after_last", done_words, v.n);
        chk("dump_idle_busy", busy, 0);
        chk("dump_idle_valid", dout_valid, 0);
        if (v.stall_at < 0) begin
            chk("dump_first_cycle", first_cyc, 0);
            chk("dump_last_cycle", last_cyc, v.n - 1);
        end
    endtask

    initial begin
        int dsum;
        vecs[0] = '{5'd1,  6'd3, 3,  32'd1,  -1};
        vecs[1] = '{5'd2,  6'd8, 8,  32'd2,   3};
        vecs[2] = '{5'd30, 6'd4, 4,  32'd30, -1};
        vecs[3] = '{5'd0,  6'd0, 32, 32'd0,  -1};
        vecs[4] = '{5'd31, 6'd1, 1,  32'd31, -1};
        vecs[5] = '{5'd28, 6'd6, 6,  32'd28,  0};

        preload_req = 1'b1;
        repeat (2) @(negedge clk);
        preload_req = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_data", dout_data, 0);
        chk("rst_rf_ra", rf_ra, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_din_ready", din_ready, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_dump(vecs[i]);

        // Load base=0 count=2: R0 write suppressed, R1 written.
        @(negedge clk);
        base = 5'd0; count = 6'd2; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_din_ready", din_ready, 1);
        din_valid = 1'b1; din_data = 32'hDEADBEEF;
        #1 chk("load_r0_suppress", rf_we, 0);
        @(negedge clk);
        din_data = 32'h12345678;
        #1 chk("load_we", rf_we, 1);
        chk("load_wa", rf_wa, 1);
        chk("load_wd", rf_wd, 32'h12345678);
        @(negedge clk);
        din_valid = 1'b0;
        chk("load_done", done, 1);
        chk("load_din_ready_off", din_ready, 0);
        chk("load_we_off", rf_we, 0);
        @(negedge clk);
        chk("load_done_once", done, 0);
        chk("load_idle", busy, 0);
        chk("load_r0", rf[0], 0);
        chk("load_r1", rf[1], 32'h12345678);

        // Abort in the third DUMP cycle.
        @(negedge clk);
        base = 5'd4; count = 6'd8; mode = 1'b0; start = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abd_word0", dout_data, 4);
        @(negedge clk);
        chk("abd_word1", dout_data, 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abd_busy", busy, 0);
        chk("abd_valid", dout_valid, 0);
        dsum = done;
        repeat (3) begin @(negedge clk); dsum += done; end
        chk("abd_no_done", dsum, 0);

        // Abort colliding with a load handshake.
        @(negedge clk);
        base = 5'd16; count = 6'd4; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; din_valid = 1'b1; din_data = 32'hA0;
        @(negedge clk);
        din_data = 32'hA1; abort = 1'b1;
        #1 chk("abl_prio_we", rf_we, 0);
        @(negedge clk);
        abort = 1'b0; din_valid = 1'b0;
        chk("abl_busy", busy, 0);
        chk("abl_done", done, 0);
        chk("abl_r16", rf[16], 32'hA0);
        chk("abl_r17", rf[17], 17);

        // Reset pulse mid-load.
        @(negedge clk);
        base = 5'd8; count = 6'd6; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; din_valid = 1'b1; din_data = 32'h55000008;
        @(negedge clk);
        din_data = 32'h55000009;
        @(negedge clk);
        din_data = 32'h5500000A; rst_n = 1'b0;
        #1 chk("rml_busy", busy, 0);
        chk("rml_valid", dout_valid, 0);
        chk("rml_we", rf_we, 0);
        @(negedge clk);
        rst_n = 1'b1; din_valid = 1'b0;
        dsum = done;
        repeat (3) begin @(negedge clk); dsum += done; end
        chk("rml_no_done", dsum, 0);
        chk("rml_r8", rf[8], 32'h55000008);
        chk("rml_r9", rf[9], 32'h55000009);
        chk("rml_r10", rf[10], 10);
        chk("rml_r11", rf[11], 11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
